add_round_key_word: RTL and testbench

//  Word-serial AddRoundKey stage, directly downstream of mix_columns. Takes one 32-bit

---
 rtl/add_round_key_word_if.sv | 40 ++++
 rtl/add_round_key_word.sv | 143 ++++++++++++++
 tb/tb_add_round_key_word.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_word_if.sv
// Bus bundle for the word-serial AddRoundKey stage: key load, word in/out, status.
// ADD_ROUND_KEY_PARITY_EN adds the per-byte output parity signal.
interface add_round_key_word_if;
  logic         start;
  logic [127:0] round_key_in;
  logic         round_key_vld;
  logic         key_req;
  logic [31:0]  word_in_comb_mix_column;
  logic         word_in_comb_mix_column_vld;
  logic [31:0]  word_out_add_round_key;
  logic         word_out_add_round_key_vld;
  logic         state_done;
  logic         block_done;
  logic [3:0]   round_cnt;
  logic         err_no_key;
  logic         err_key_overrun;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [3:0]   word_out_add_round_key_par;
`endif

  modport master (
    output start, round_key_in, round_key_vld,
           word_in_comb_mix_column, word_in_comb_mix_column_vld,
    input  key_req, word_out_add_round_key, word_out_add_round_key_vld,
           state_done, block_done, round_cnt, err_no_key, err_key_overrun
`ifdef ADD_ROUND_KEY_PARITY_EN
    , input word_out_add_round_key_par
`endif
  );

  modport slave (
    input  start, round_key_in, round_key_vld,
           word_in_comb_mix_column, word_in_comb_mix_column_vld,
    output key_req, word_out_add_round_key, word_out_add_round_key_vld,
           state_done, block_done, round_cnt, err_no_key, err_key_overrun
`ifdef ADD_ROUND_KEY_PARITY_EN
    , output word_out_add_round_key_par
`endif
  );
endinterface

// File: rtl/add_round_key_word.sv
// Word-serial AddRoundKey: XORs each column word with the active round key word,
// with a one-deep shadow key slot. Optional ADD_ROUND_KEY_PARITY_EN adds byte parity.
module add_round_key_word #(
  parameter int WORDS_PER_STATE = 4,
  parameter int NUM_ROUNDS      = 10
) (
  input logic                 clock,
  input logic                 reset_n,
  add_round_key_word_if.slave bus
);
  localparam int WCW = (WORDS_PER_STATE > 1) ? $clog2(WORDS_PER_STATE) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(WORDS_PER_STATE - 1);

  typedef logic [WORDS_PER_STATE-1:0][31:0] key_t;
  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e         state_q, state_d;
  key_t           act_key_q, shd_key_q;
  logic           shd_full_q, shd_full_d;
  logic [WCW-1:0] word_cnt_q;
  logic [3:0]     rnd_q, rnd_next;
  logic           rdy_q;
  logic           acc, last, ld_act, ld_shd, xfer, set_ovr;
  logic [31:0]    key_word, res;
  logic [31:0]    out_q;
  logic           out_vld_q, done_q, blk_q, nokey_q, ovr_q;

  // word0 sits in the top 32 bits, i.e. the highest packed index
  assign key_word = act_key_q[LAST - word_cnt_q];
  assign res      = bus.word_in_comb_mix_column ^ key_word;
  assign rnd_next = (rnd_q >= 4'(NUM_ROUNDS)) ? 4'd1 : rnd_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    shd_full_d = shd_full_q;
    ld_act     = 1'b0;
    ld_shd     = 1'b0;
    xfer       = 1'b0;
    set_ovr    = 1'b0;
    acc        = (state_q == ACTIVE) && bus.word_in_comb_mix_column_vld;
    last       = acc && (word_cnt_q == LAST);
    unique case (state_q)
      IDLE: if (bus.round_key_vld) begin
        ld_act  = 1'b1;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (last) begin
          // a key arriving on the boundary cycle fills whichever slot frees up
          if (shd_full_q) begin
            xfer       = 1'b1;
            ld_shd     = bus.round_key_vld;
            shd_full_d = bus.round_key_vld;
          end else if (bus.round_key_vld) begin
            ld_act = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.round_key_vld) begin
          if (shd_full_q) set_ovr = 1'b1;
          else begin
            ld_shd     = 1'b1;
            shd_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       state_q <= IDLE;
    else if (bus.start) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      act_key_q  <= '0;
      shd_key_q  <= '0;
      shd_full_q <= 1'b0;
      word_cnt_q <= '0;
      rnd_q      <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      blk_q      <= 1'b0;
      nokey_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (bus.start) begin
        act_key_q  <= '0;
        shd_key_q  <= '0;
        shd_full_q <= 1'b0;
        word_cnt_q <= '0;
        rnd_q      <= '0;
        out_vld_q  <= 1'b0;
        done_q     <= 1'b0;
        blk_q      <= 1'b0;
        nokey_q    <= 1'b0;
        ovr_q      <= 1'b0;
      end else begin
        shd_full_q <= shd_full_d;
        if (ld_act)    act_key_q <= bus.round_key_in;
        else if (xfer) act_key_q <= shd_key_q;
        if (ld_shd)    shd_key_q <= bus.round_key_in;
        if (ld_act || xfer) rnd_q <= rnd_next;
        if (acc) begin
          word_cnt_q <= last ? '0 : word_cnt_q + WCW'(1);
          out_q      <= res;
        end
        out_vld_q <= acc;
        done_q    <= last;
        blk_q     <= last && (rnd_q == 4'(NUM_ROUNDS));
        if (set_ovr) ovr_q <= 1'b1;
        if (bus.word_in_comb_mix_column_vld && state_q == IDLE) nokey_q <= 1'b1;
      end
    end
  end

`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [3:0] par_d, par_q;
  for (genvar i = 0; i < 4; i++) begin : g_par
    assign par_d[i] = ^res[8*i +: 8];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  par_q <= '0;
    else if (!bus.start && acc)    par_q <= par_d;
  end
  assign bus.word_out_add_round_key_par = par_q;
`endif

  assign bus.key_req                    = rdy_q && !shd_full_q;
  assign bus.word_out_add_round_key     = out_q;
  assign bus.word_out_add_round_key_vld = out_vld_q;
  assign bus.state_done                 = done_q;
  assign bus.block_done                 = blk_q;
  assign bus.round_cnt                  = rnd_q;
  assign bus.err_no_key                 = nokey_q;
  assign bus.err_key_overrun            = ovr_q;
endmodule

// File: tb/tb_add_round_key_word.sv
// Directed bench for add_round_key_word: reset, single state, back-to-back rounds,
// errors, word-3 boundary keys, 10-round wrap and mid-state reset.
module tb_add_round_key_word;
  logic clock, reset_n;
  int checks = 0;
  int errors = 0;

  add_round_key_word_if bus ();
  add_round_key_word dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rkey(input int r);
    return {4{32'(r)}};
  endfunction

  logic [31:0] w2 [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  // 8899aabb ^ 08090a0b = 8090a0b0
  logic [31:0] e2 [4] = '{32'h00102030, 32'h40506070, 32'h8090a0b0, 32'hc0d0e0f0};
  // 01234567 xor each word of K2 then K3
  logic [31:0] e3 [8] = '{32'h10325476, 32'h23016745, 32'h32107654, 32'h45670123,
                          32'ha486e0c2, 32'h5b791f3d, 32'h0e2c4a68, 32'hf1d3b597};
  logic [127:0] k4 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  logic [31:0]  k4w [4] = '{32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0};

  initial begin
    reset_n = 1'b1;
    bus.start = 1'b0;
    bus.round_key_in = '0;
    bus.round_key_vld = 1'b0;
    bus.word_in_comb_mix_column = '0;
    bus.word_in_comb_mix_column_vld = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    // reset
    chk("rst_vld",    bus.word_out_add_round_key_vld, 0);
    chk("rst_out",    bus.word_out_add_round_key, 0);
    chk("rst_keyreq", bus.key_req, 0);
    chk("rst_rc",     bus.round_cnt, 0);
    chk("rst_done",   {bus.state_done, bus.block_done, bus.err_no_key, bus.err_key_overrun}, 0);
    tick(); tick();
    chk("rst_keyreq_clk", bus.key_req, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_keyreq", bus.key_req, 1);
    chk("rel_rc",     bus.round_cnt, 0);

    // single state
    bus.round_key_in = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    bus.round_key_vld = 1'b1;
    tick();
    bus.round_key_vld = 1'b0;
    chk("t2_rc", bus.round_cnt, 1);
    chk("t2_keyreq", bus.key_req, 1);
    for (int i = 0; i < 4; i++) begin
      bus.word_in_comb_mix_column = w2[i];
      bus.word_in_comb_mix_column_vld = 1'b1;
      tick();
      chk($sformatf("t2_out%0d", i), bus.word_out_add_round_key, e2[i]);
      chk($sformatf("t2_vld%0d", i), bus.word_out_add_round_key_vld, 1);
      chk($sformatf("t2_done%0d", i), bus.state_done, (i == 3));
`ifdef ADD_ROUND_KEY_PARITY_EN
      // bit i covers word[8i+7:8i]: 00102030 -> bytes 30,20,10,00 -> 0110
      if (i == 0) chk("t2_par", bus.word_out_add_round_key_par, 4'b0110);
`endif
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    tick();
    chk("t2_idle_vld", bus.word_out_add_round_key_vld, 0);
    chk("t2_hold",     bus.word_out_add_round_key, 32'hc0d0e0f0);
    chk("t2_done_off", bus.state_done, 0);

    // word with no key
    bus.word_in_comb_mix_column = 32'h12345678;
    bus.word_in_comb_mix_column_vld = 1'b1;
    tick();
    bus.word_in_comb_mix_column_vld = 1'b0;
    chk("nokey_vld",  bus.word_out_add_round_key_vld, 0);
    chk("nokey_err",  bus.err_no_key, 1);
    chk("nokey_hold", bus.word_out_add_round_key, 32'hc0d0e0f0);

    // start wins over same-cycle key and word
    bus.start = 1'b1;
    bus.round_key_vld = 1'b1;
    bus.word_in_comb_mix_column_vld = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.round_key_vld = 1'b0;
    bus.word_in_comb_mix_column_vld = 1'b0;
    chk("start_nokey", bus.err_no_key, 0);
    chk("start_rc",    bus.round_cnt, 0);
    chk("start_vld",   bus.word_out_add_round_key_vld, 0);
    chk("start_kreq",  bus.key_req, 1);
    tick();
    chk("start_rc2",   bus.round_cnt, 0);

    // back-to-back rounds with shadow preload; K4 arrives on the word-3 transfer cycle
    bus.round_key_in = 128'h11111111_22222222_33333333_44444444;
    bus.round_key_vld = 1'b1;
    tick();
    bus.round_key_in = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    tick();
    bus.round_key_vld = 1'b0;
    chk("t3_kreq", bus.key_req, 0);
    chk("t3_rc",   bus.round_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      bus.word_in_comb_mix_column = 32'h01234567;
      bus.word_in_comb_mix_column_vld = 1'b1;
      bus.round_key_in = k4;
      bus.round_key_vld = (i == 3);
      tick();
      chk($sformatf("t3_out%0d", i), bus.word_out_add_round_key, e3[i]);
      chk($sformatf("t3_vld%0d", i), bus.word_out_add_round_key_vld, 1);
      chk($sformatf("t3_done%0d", i), bus.state_done, (i % 4 == 3));
      chk($sformatf("t3_rc%0d", i), bus.round_cnt, (i < 3) ? 1 : (i < 7) ? 2 : 3);
      chk($sformatf("t3_kreq%0d", i), bus.key_req, (i == 7));
      chk($sformatf("t3_ovr%0d", i), bus.err_key_overrun, 0);
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    bus.round_key_vld = 1'b0;

    // overrun: K5 fills shadow, K6 is dropped
    bus.round_key_in = 128'h13579bdf_2468ace0_fedcba98_76543210;
    bus.round_key_vld = 1'b1;
    tick();
    chk("ovr_kreq", bus.key_req, 0);
    chk("ovr_pre",  bus.err_key_overrun, 0);
    bus.round_key_in = {4{32'hffffffff}};
    tick();
    bus.round_key_vld = 1'b0;
    chk("ovr_set", bus.err_key_overrun, 1);
    for (int i = 0; i < 5; i++) begin
      bus.word_in_comb_mix_column = 32'h0;
      bus.word_in_comb_mix_column_vld = 1'b1;
      tick();
      chk($sformatf("ovr_out%0d", i), bus.word_out_add_round_key,
          (i < 4) ? k4w[i] : 32'h13579bdf);
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    chk("ovr_rc", bus.round_cnt, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ovr_clr", bus.err_key_overrun, 0);
    chk("ovr_clr_rc", bus.round_cnt, 0);

    // ten rounds, each next key on the word-3 cycle with an empty shadow
    bus.round_key_in = rkey(1);
    bus.round_key_vld = 1'b1;
    tick();
    for (int r = 1; r <= 10; r++) begin
      for (int w = 0; w < 4; w++) begin
        bus.word_in_comb_mix_column = 32'ha5000000 | 32'(w);
        bus.word_in_comb_mix_column_vld = 1'b1;
        bus.round_key_in = rkey(r + 1);
        bus.round_key_vld = (w == 3 && r < 10);
        tick();
        chk($sformatf("wr_out%0d_%0d", r, w), bus.word_out_add_round_key,
            (32'ha5000000 | 32'(w)) ^ 32'(r));
        chk($sformatf("wr_blk%0d_%0d", r, w), bus.block_done, (r == 10 && w == 3));
        chk($sformatf("wr_rc%0d_%0d", r, w), bus.round_cnt,
            (w == 3 && r < 10) ? r + 1 : r);
        chk($sformatf("wr_ovr%0d_%0d", r, w), bus.err_key_overrun, 0);
      end
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    bus.round_key_vld = 1'b0;
    tick();
    chk("wr_blk_off", bus.block_done, 0);
    chk("wr_rc_hold", bus.round_cnt, 10);
    bus.round_key_in = rkey(1);
    bus.round_key_vld = 1'b1;
    tick();
    bus.round_key_vld = 1'b0;
    chk("wr_rc_wrap", bus.round_cnt, 1);

    // reset after word 1 of a state
    for (int w = 0; w < 2; w++) begin
      bus.word_in_comb_mix_column = 32'h0;
      bus.word_in_comb_mix_column_vld = 1'b1;
      tick();
      chk($sformatf("mr_out%0d", w), bus.word_out_add_round_key, 32'h1);
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mr_vld",  bus.word_out_add_round_key_vld, 0);
    chk("mr_out",  bus.word_out_add_round_key, 0);
    chk("mr_rc",   bus.round_cnt, 0);
    chk("mr_kreq", bus.key_req, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mr_kreq_rel", bus.key_req, 1);
    for (int w = 2; w < 4; w++) begin
      bus.word_in_comb_mix_column = 32'h0;
      bus.word_in_comb_mix_column_vld = 1'b1;
      tick();
      chk($sformatf("mr_vld%0d", w),  bus.word_out_add_round_key_vld, 0);
      chk($sformatf("mr_done%0d", w), bus.state_done, 0);
    end
    bus.word_in_comb_mix_column_vld = 1'b0;
    chk("mr_nokey", bus.err_no_key, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
